// File: rtl/serial_adder_ctrl.sv
// Purpose: bit-serial add/subtract, one full-adder cell sequenced LSB first by a small FSM.
// Latency: done pulses in the cycle after edge k+N; one operation per N+2 cycles.
// Backpressure: start is sampled only in IDLE; a start while busy is dropped, not queued.

// Purpose: 1-bit full adder cell.
// Latency: combinational.
// Backpressure: none.
module fulladder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ cin;
  assign co = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder_ctrl #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         ovf
);
  localparam int            CW       = $clog2(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
  localparam logic [CW-1:0] CNT_MSB  = CW'(N - 2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  opa_q, opa_d;
  logic [N-1:0]  opb_q, opb_d;
  // Holds the N-1 sum bits already produced; the last bit comes straight from the cell.
  logic [N-2:0]  res_q, res_d;
  logic          carry_q, carry_d;
  logic          cmsb_q, cmsb_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  sum_q, sum_d;
  logic          cout_q, cout_d;
  logic          ovf_q, ovf_d;

  logic          fa_s;
  logic          fa_co;
  logic [N-1:0]  res_full;

  fulladder u_fa (
    .a   (opa_q[0]),
    .b   (opb_q[0]),
    .cin (carry_q),
    .s   (fa_s),
    .co  (fa_co)
  );

  // New sum bit enters at the MSB; on the final step this is the complete result.
  assign res_full = {fa_s, res_q};

  // Next-state and datapath: load on accepted start, shift one bit per RUN cycle.
  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    carry_d = carry_q;
    cmsb_d  = cmsb_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          opa_d   = a;
          opb_d   = sub ? ~b : b;
          carry_d = sub;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        opa_d   = {1'b0, opa_q[N-1:1]};
        opb_d   = {1'b0, opb_q[N-1:1]};
        res_d   = res_full[N-1:1];
        carry_d = fa_co;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CNT_MSB) begin
          cmsb_d = fa_co;
        end
        if (cnt_q == CNT_LAST) begin
          sum_d   = res_full;
          cout_d  = fa_co;
          ovf_d   = cmsb_q ^ fa_co;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cmsb_q  <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cmsb_q  <= cmsb_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Purpose: randomized self-checking bench for serial_adder_ctrl at N=8 and N=2.
// Latency: expects done in the cycle after edge k+N and busy for N+1 cycles.
// Backpressure: checks that starts while busy are ignored.
module tb_serial_adder_ctrl;
  logic       clk;
  logic       reset;

  logic       start8, sub8;
  logic [7:0] a8, b8;
  logic       busy8, done8, cout8, ovf8;
  logic [7:0] sum8;

  logic       start2, sub2;
  logic [1:0] a2, b2;
  logic       busy2, done2, cout2, ovf2;
  logic [1:0] sum2;

  int checks;
  int errors;

  logic [33:0] last8;
  logic [33:0] last2;
  logic [33:0] hq [0:63];

  serial_adder_ctrl #(.N(8)) u_dut8 (
    .clk(clk), .reset(reset), .start(start8), .a(a8), .b(b8), .sub(sub8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  serial_adder_ctrl #(.N(2)) u_dut2 (
    .clk(clk), .reset(reset), .start(start2), .a(a2), .b(b2), .sub(sub2),
    .busy(busy2), .done(done2), .sum(sum2), .cout(cout2), .ovf(ovf2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic, returns {ovf, cout, sum}.
  function automatic logic [33:0] ref_op(input int w, input longint x, input longint y, input bit s);
    longint m, xa, ya, r, sx, sy, t;
    bit co, ov;
    m  = longint'(1) << w;
    xa = x & (m - 1);
    ya = y & (m - 1);
    if (s) begin
      r  = xa - ya;
      co = (xa >= ya);
    end else begin
      r  = xa + ya;
      co = (r >= m);
    end
    r  = r & (m - 1);
    sx = (xa >= m / 2) ? xa - m : xa;
    sy = (ya >= m / 2) ? ya - m : ya;
    t  = s ? sx - sy : sx + sy;
    ov = (t < -(m / 2)) || (t >= m / 2);
    return {ov, co, 32'(r)};
  endfunction

  task automatic run_op8(input logic [7:0] x, input logic [7:0] y, input logic s);
    logic [33:0] e;
    int c;
    int nbusy;
    e = ref_op(8, x, y, s);
    @(negedge clk);
    start8 = 1'b1; a8 = x; b8 = y; sub8 = s;
    @(negedge clk);
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom);
    c = 1;
    nbusy = 0;
    check("hold_sum8", 32'(sum8), last8[31:0]);
    while (done8 !== 1'b1 && c < 40) begin
      if (busy8) nbusy++;
      @(negedge clk);
      c++;
    end
    if (busy8) nbusy++;
    check("done_lat8", c, 9);
    check("busy_cyc8", nbusy, 9);
    check("sum8", 32'(sum8), e[31:0]);
    check("cout8", 32'(cout8), 32'(e[32]));
    check("ovf8", 32'(ovf8), 32'(e[33]));
    last8 = e;
    @(negedge clk);
    check("done_pulse8", 32'(done8), 0);
    check("idle_busy8", 32'(busy8), 0);
  endtask

  task automatic run_op2(input logic [1:0] x, input logic [1:0] y, input logic s);
    logic [33:0] e;
    int c;
    e = ref_op(2, x, y, s);
    @(negedge clk);
    start2 = 1'b1; a2 = x; b2 = y; sub2 = s;
    @(negedge clk);
    start2 = 1'b0; a2 = 2'($urandom); b2 = 2'($urandom); sub2 = 1'($urandom);
    c = 1;
    while (done2 !== 1'b1 && c < 20) begin
      @(negedge clk);
      c++;
    end
    check("done_lat2", c, 3);
    check("sum2", 32'(sum2), e[31:0]);
    check("cout2", 32'(cout2), 32'(e[32]));
    check("ovf2", 32'(ovf2), 32'(e[33]));
    last2 = e;
    @(negedge clk);
    check("done_pulse2", 32'(done2), 0);
  endtask

  initial begin
    int seen;
    logic exp_done;
    checks = 0;
    errors = 0;
    last8 = '0;
    last2 = '0;
    reset = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; sub8 = 1'b0;
    start2 = 1'b0; a2 = '0; b2 = '0; sub2 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy8", 32'(busy8), 0);
    check("rst_done8", 32'(done8), 0);
    check("rst_sum8", 32'(sum8), 0);
    check("rst_cout8", 32'(cout8), 0);
    check("rst_ovf8", 32'(ovf8), 0);
    check("rst_busy2", 32'(busy2), 0);
    reset = 1'b0;

    // Directed corner cases.
    run_op8(8'h35, 8'h4A, 1'b0);
    run_op8(8'hFF, 8'h01, 1'b0);
    run_op8(8'h7F, 8'h01, 1'b0);
    run_op8(8'h05, 8'h07, 1'b1);
    run_op8(8'h80, 8'h01, 1'b1);

    // Random operations.
    for (int i = 0; i < 30; i++) begin
      run_op8(8'($urandom), 8'($urandom), 1'($urandom));
    end

    // Start held high with operands changing every cycle.
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      exp_done = (t >= 9) && (((t - 9) % 10) == 0);
      check("held_done", 32'(done8), 32'(exp_done));
      if (exp_done) begin
        check("held_sum", 32'(sum8), hq[t-9][31:0]);
        check("held_cout", 32'(cout8), 32'(hq[t-9][32]));
        check("held_ovf", 32'(ovf8), 32'(hq[t-9][33]));
      end
      start8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom);
      hq[t] = ref_op(8, a8, b8, sub8);
    end
    start8 = 1'b0;
    last8 = hq[20];

    // Reset in the middle of an operation.
    run_op8(8'h80, 8'h01, 1'b1);
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h55; b8 = 8'h22; sub8 = 1'b0;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", 32'(busy8), 0);
    check("abort_done", 32'(done8), 0);
    check("abort_sum", 32'(sum8), 0);
    check("abort_cout", 32'(cout8), 0);
    check("abort_ovf", 32'(ovf8), 0);
    last8 = '0;
    last2 = '0;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8) seen = 1;
    end
    check("abort_no_done", seen, 0);
    run_op8(8'h10, 8'h20, 1'b0);
    check("post_abort_sum", 32'(sum8), 32'h30);

    // N=2 instance.
    run_op2(2'b11, 2'b01, 1'b0);
    check("n2_sum_0", 32'(sum2), 0);
    for (int i = 0; i < 20; i++) begin
      run_op2(2'($urandom), 2'($urandom), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
